mux_scan_n1: RTL and testbench
==============================

Name: mux_scan_n1

Overview:
- Parametrised N:1 channel selector with a registered output and a valid/ready output handshake.
- Each sample is taken from a NUM_CH x DATA_W flat input bus.
- Two selection modes:
  - Manual: the software-loaded select register picks the channel.
  - Scan: round-robin over the channels enabled in a mask, skipping disabled ones.
- Sits between raw sensor/status lanes and a single downstream consumer.

Parameters:
- NUM_CH, 16, number of input channels (>=2).
- DATA_W, 1, width of each channel in bits.
- SEL_W, $clog2(NUM_CH), derived localparam; select and channel-index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; 0 blocks new samples
- mode  input  1  0 = manual, 1 = scan
- in_bus  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- ch_mask  input  NUM_CH  scan-mode channel enables; ignored in manual mode
- sel_in  input  SEL_W  manual select value
- sel_load  input  1  loads sel_in into sel_q
- sel_err  output  1  one-cycle pulse: rejected sel_load
- out_data  output  DATA_W  captured sample
- out_ch  output  SEL_W  channel index of out_data
- out_valid  output  1  sample held
- out_ready  input  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset (asynchronous on rst_n low): out_data=0, out_ch=0, out_valid=0, sel_q=0, scan pointer ptr=0, sel_err=0.
- Slot free: slot_free = !out_valid | out_ready.
- Capture condition: capture = slot_free & en & has_target.
- On capture, at the next edge:
  - out_data <= slice of target channel; out_ch <= target; out_valid <= 1.
  - Latency from in_bus to out_data is one cycle.
  - Full throughput: one sample per cycle while out_ready=1.
- Accept without capture: out_valid <= 0.
- Stall: out_valid=1 and out_ready=0 holds out_data/out_ch stable; in_bus changes are ignored.
- Manual mode: target = sel_q; has_target = 1.
- Scan mode:
  - target = first set bit of ch_mask searched circularly from ptr (ptr, ptr+1, ... NUM_CH-1, 0, ...).
  - has_target = |ch_mask.
  - After capture, ptr <= target+1, wrapping to 0 when target = NUM_CH-1.
  - ptr changes only on scan-mode capture.
- ch_mask all zero in scan mode: no capture; a pending sample is still delivered, then out_valid falls.
- sel_load:
  - sel_in < NUM_CH: sel_q <= sel_in.
  - sel_in >= NUM_CH (only possible for non-power-of-2 NUM_CH): sel_q unchanged, sel_err pulses for one cycle.
- sel_load coincident with a capture: the capture uses the old sel_q; the new value applies from the next capture.
- mode or ch_mask change: sampled combinationally each cycle; takes effect at the next capture. ptr is retained across mode switches.
- en=0: a held sample remains until accepted; no new captures.
- Reset mid-transfer: a pending sample is dropped; out_valid returns to 0 immediately.

Optional Feature:
- Macro: MUX_PARITY_EN
- Defined:
  - Adds output port out_par (1 bit) = XOR-reduction of the captured slice.
  - Registered with out_data; reset 0; held during stall.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - Mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - Helper function for the flat-bus slice index.
- Sub-module mux_rr_find (circular first-set finder): inputs mask[NUM_CH], start[SEL_W]; outputs idx[SEL_W], found.
- The top holds the registers, handshake and select logic.

Test Plan:
- Manual mode:
  - Setup: NUM_CH=16, DATA_W=8, in_bus channel c = 8'hA0+c.
  - Stimulus: sel_load with sel_in=5, en=1, out_ready=1.
  - Expected: out_data=8'hA5, out_ch=5, out_valid=1 one cycle after capture starts.
- Scan with mask 16'h0109, ptr=0, ready=1:
  - out_ch sequence 0, 3, 8, 0, 3…
  - Each out_data equals its channel's slice.
- Backpressure in scan mode:
  - Stimulus: out_ready=0 for 4 cycles while in_bus changes.
  - Expected: out_data/out_ch frozen, ptr frozen; on release the next channel follows with no skip or duplicate.
- Non-power-of-2 and load collision:
  - NUM_CH=12, sel_in=13 with sel_load: sel_err=1 for one cycle, sel_q keeps its previous value.
  - sel_load together with a capture: the old channel is sampled first.
- Empty mask and mode switch:
  - Scan mode, ch_mask=0: out_valid falls after accept, no captures.
  - Switch to manual mode: captures resume from sel_q.
- Reset and parity:
  - rst_n pulsed low mid-stall: all outputs 0 asynchronously.
  - With MUX_PARITY_EN defined, DATA_W=8, captured 8'hA7: out_par=1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_scan_n1 channel selector.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // LSB position of channel ch on a flat bus of w-bit lanes.
  function automatic int slice_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/mux_rr_find.sv
// Circular first-set finder: first set bit of mask at or after start, wrapping.
// Purely combinational; found=0 when mask is empty.
module mux_rr_find #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

  logic [2*NUM_CH-1:0] rot;
  int                  c;

  // Doubling the mask turns the circular search into a linear one from bit 0.
  assign rot = {mask, mask} >> start;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        c     = int'(start) + i;
        if (c >= NUM_CH) c = c - NUM_CH;
        idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_scan_n1.sv
// N:1 channel selector (manual select or masked round-robin scan) with a registered
// valid/ready output slot; optional out_par parity output under MUX_PARITY_EN.
module mux_scan_n1
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 16,
  parameter  int DATA_W = 1,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] in_bus,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_load,
  output logic                     sel_err,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
`ifdef MUX_PARITY_EN
  output logic                     out_par,
`endif
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sel_err_q, sel_err_d;
  logic              par_q, par_d;

  logic [SEL_W-1:0]  rr_idx, target;
  logic [DATA_W-1:0] sample;
  logic              rr_found, has_target, slot_free, capture, sel_ok;

  mux_rr_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_find (
    .mask  (ch_mask),
    .start (ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign target     = (mode == MODE_SCAN) ? rr_idx : sel_q;
  assign has_target = (mode == MODE_SCAN) ? rr_found : 1'b1;
  assign slot_free  = !out_valid_q || out_ready;
  assign capture    = slot_free && en && has_target;
  assign sel_ok     = int'(sel_in) < NUM_CH;

  always_comb begin
    sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (target == SEL_W'(c)) sample = in_bus[slice_lsb(c, DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    par_d       = par_q;
    if (capture) begin
      out_data_d  = sample;
      out_ch_d    = target;
      out_valid_d = 1'b1;
      par_d       = ^sample;
      if (mode == MODE_SCAN) begin
        ptr_d = (target == SEL_W'(NUM_CH - 1)) ? '0 : target + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A load landing with a capture only affects the following capture, since the
  // capture above reads sel_q rather than sel_d.
  always_comb begin
    sel_d     = sel_q;
    sel_err_d = 1'b0;
    if (sel_load) begin
      if (sel_ok) sel_d = sel_in;
      else        sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      ptr_q       <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      par_q       <= par_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_PARITY_EN
  assign out_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_n1.sv
// Bench for mux_scan_n1: directed scenarios plus randomized run against a behavioural model.
module tb_mux_scan_n1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  // 16-channel, 8-bit instance
  logic         en = 0, mode = 0, sel_load = 0, out_ready = 0;
  logic [127:0] in_bus = '0;
  logic [15:0]  ch_mask = '0;
  logic [3:0]   sel_in = '0;
  logic         sel_err, out_valid, out_par;
  logic [7:0]   out_data;
  logic [3:0]   out_ch;

  // 12-channel, 8-bit instance (non-power-of-2 select range)
  logic         b_en = 0, b_mode = 0, b_sel_load = 0, b_out_ready = 1;
  logic [95:0]  b_in_bus = '0;
  logic [11:0]  b_ch_mask = '0;
  logic [3:0]   b_sel_in = '0;
  logic         b_sel_err, b_out_valid, b_out_par;
  logic [7:0]   b_out_data;
  logic [3:0]   b_out_ch;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the 16-channel instance
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch, m_ptr, m_sel;

  always #5 clk = ~clk;

  mux_scan_n1 #(.NUM_CH(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_bus(in_bus),
    .ch_mask(ch_mask), .sel_in(sel_in), .sel_load(sel_load), .sel_err(sel_err),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready)
  );

  mux_scan_n1 #(.NUM_CH(12), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .in_bus(b_in_bus),
    .ch_mask(b_ch_mask), .sel_in(b_sel_in), .sel_load(b_sel_load), .sel_err(b_sel_err),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
`ifdef MUX_PARITY_EN
    .out_par(b_out_par),
`endif
    .out_ready(b_out_ready)
  );

`ifndef MUX_PARITY_EN
  assign out_par   = 1'b0;
  assign b_out_par = 1'b0;
`endif

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_sel = 0;
  endtask

  // Advance the model on the current inputs, then let the DUT take the same edge.
  task automatic tick();
    int t, c;
    bit has;
    has = 1; t = m_sel;
    if (mode) begin
      has = 0;
      for (int k = 0; k < 16; k++) begin
        c = (m_ptr + k) % 16;
        if (!has && ch_mask[c]) begin has = 1; t = c; end
      end
    end
    if ((!m_valid || out_ready) && en && has) begin
      m_valid = 1; m_data = in_bus[t*8 +: 8]; m_ch = t;
      if (mode) m_ptr = (t + 1) % 16;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (sel_load && sel_in < 16) m_sel = sel_in;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int c = 0; c < 16; c++) in_bus[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 12; c++) b_in_bus[c*8 +: 8] = 8'hB0 + 8'(c);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++; if (out_ch !== 4'h0) begin errors++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %0b want 0", sel_err); end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_manual();
    fill_pattern();
    mode = 0; out_ready = 1; en = 0; sel_load = 1; sel_in = 4'd5;
    tick();
    sel_load = 0; en = 1;
    tick();
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL manual_data got %h want a5", out_data); end
    checks++; if (out_ch !== 4'd5) begin errors++; $display("FAIL manual_ch got %0d want 5", out_ch); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL manual_valid got %0b want 1", out_valid); end
  endtask

  task automatic test_scan();
    int seq [3] = '{0, 3, 8};
    mode = 1; ch_mask = 16'h0109; en = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_ch !== 4'(seq[i%3])) begin errors++; $display("FAIL scan_ch[%0d] got %0d want %0d", i, out_ch, seq[i%3]); end
      checks++; if (out_data !== 8'hA0 + 8'(seq[i%3])) begin errors++; $display("FAIL scan_data[%0d] got %h want %h", i, out_data, 8'hA0 + 8'(seq[i%3])); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_bus = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++; if (out_ch !== 4'd8 || out_data !== 8'hA8) begin errors++; $display("FAIL stall_hold[%0d] got ch=%0d data=%h want ch=8 data=a8", i, out_ch, out_data); end
    end
    out_ready = 1;
    in_bus = {$urandom, $urandom, $urandom, $urandom};
    tick();
    checks++; if (out_ch !== 4'd0 || out_data !== in_bus[7:0]) begin errors++; $display("FAIL release_first got ch=%0d data=%h want ch=0 data=%h", out_ch, out_data, in_bus[7:0]); end
    tick();
    checks++; if (out_ch !== 4'd3 || out_data !== in_bus[31:24]) begin errors++; $display("FAIL release_second got ch=%0d data=%h want ch=3 data=%h", out_ch, out_data, in_bus[31:24]); end
  endtask

  task automatic test_empty_mask();
    fill_pattern();
    ch_mask = '0; out_ready = 0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_pending got %0b want 1", out_valid); end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_drain got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_idle got %0b want 0", out_valid); end
    mode = 0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 4'd5 || out_data !== 8'hA5) begin errors++; $display("FAIL manual_resume got v=%0b ch=%0d data=%h want v=1 ch=5 data=a5", out_valid, out_ch, out_data); end
  endtask

  task automatic test_nonpow2();
    b_mode = 0; b_en = 0; b_out_ready = 1; b_sel_load = 1; b_sel_in = 4'd3;
    tick();
    checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL np2_good_load got err=%0b want 0", b_sel_err); end
    b_sel_in = 4'd13;
    tick();
    checks++; if (b_sel_err !== 1'b1) begin errors++; $display("FAIL np2_bad_load got err=%0b want 1", b_sel_err); end
    b_sel_load = 0;
    tick();
    checks++; if (b_sel_err !== 1'b0) begin errors++; $display("FAIL np2_err_pulse got err=%0b want 0", b_sel_err); end
    b_en = 1;
    tick();
    checks++; if (b_out_ch !== 4'd3 || b_out_data !== 8'hB3) begin errors++; $display("FAIL np2_sel_kept got ch=%0d data=%h want ch=3 data=b3", b_out_ch, b_out_data); end
    b_sel_load = 1; b_sel_in = 4'd7;
    tick();
    checks++; if (b_out_ch !== 4'd3) begin errors++; $display("FAIL collision_old got ch=%0d want 3", b_out_ch); end
    b_sel_load = 0;
    tick();
    checks++; if (b_out_ch !== 4'd7 || b_out_data !== 8'hB7) begin errors++; $display("FAIL collision_new got ch=%0d data=%h want ch=7 data=b7", b_out_ch, b_out_data); end
    b_en = 0;
  endtask

  task automatic test_parity();
`ifdef MUX_PARITY_EN
    fill_pattern();
    mode = 0; en = 1; out_ready = 1; sel_load = 1; sel_in = 4'd7;
    tick();
    sel_load = 0;
    tick();
    checks++; if (out_data !== 8'hA7 || out_par !== 1'b1) begin errors++; $display("FAIL parity_a7 got data=%h par=%0b want data=a7 par=1", out_data, out_par); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    mode = 0; en = 1; out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'h0 || sel_err !== 1'b0 || out_par !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%0b data=%h ch=%0d err=%0b par=%0b want all 0", out_valid, out_data, out_ch, sel_err, out_par);
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_bus    = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       ch_mask = '0;
        1:       ch_mask = 16'(1) << $urandom_range(0, 15);
        default: ch_mask = 16'($urandom);
      endcase
      sel_load  = ($urandom_range(0, 3) == 0);
      sel_in    = 4'($urandom);
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, out_valid, m_valid); end
      checks++; if (out_data !== m_data || out_ch !== 4'(m_ch)) begin errors++; $display("FAIL rand_out[%0d] got ch=%0d data=%h want ch=%0d data=%h", i, out_ch, out_data, m_ch, m_data); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rand_sel_err[%0d] got %0b want 0", i, sel_err); end
`ifdef MUX_PARITY_EN
      checks++; if (out_par !== ^m_data) begin errors++; $display("FAIL rand_par[%0d] got %0b want %0b", i, out_par, ^m_data); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_empty_mask();
    test_nonpow2();
    test_parity();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
